// File: rtl/spi_xfer_queue.sv
// -----------------------------------------------------------------------------
// spi_xfer_queue
//
// Transfer sequencer placed in front of the SPI parallel master. Words written
// by a producer are buffered in a TX FIFO; one master transfer is launched per
// word. Each received word is written into an RX FIFO for a consumer.
//
// Handshakes: a word moves across a valid/ready pair exactly on a rising clk
// edge where both valid and ready are 1. tx_ready and rx_valid depend only on
// registered state, never on the same-cycle partner signal.
//
// Optional feature macro: SPI_XQ_GAP_EN
//   defined   : after each stored word the FSM idles in GAP for GAP_CYCLES
//               clocks (active = 1, m_start = 0) so the slave sees a minimum
//               chip-select-deasserted time.
//   undefined : WAIT_DONE returns straight to IDLE; GAP_CYCLES is ignored.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   tx_valid/ready/data   producer side, push into the TX FIFO
//   rx_valid/ready/data   consumer side, pop from the RX FIFO (rx_data = head)
//   tx_level, rx_level    FIFO occupancies
//   active                a transfer (or inter-transfer gap) is in progress
//   m_start, m_data_out   to the master; m_data_out holds for the transfer
//   m_busy, m_done        from the master
//   m_data_in             word received by the master
// -----------------------------------------------------------------------------
module spi_xfer_queue #(
    parameter int DATA_BITS  = 8,
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    input  logic [DATA_BITS-1:0]   tx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [DATA_BITS-1:0]   rx_data,
    output logic [$clog2(DEPTH):0] tx_level,
    output logic [$clog2(DEPTH):0] rx_level,
    output logic                   active,
    output logic                   m_start,
    output logic [DATA_BITS-1:0]   m_data_out,
    input  logic                   m_busy,
    input  logic                   m_done,
    input  logic [DATA_BITS-1:0]   m_data_in
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GAP_CYCLES < 1) begin : g_param_check
        $error("spi_xfer_queue: DEPTH must be a power of two >= 2 and GAP_CYCLES >= 1");
    end

`ifdef SPI_XQ_GAP_EN
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_t;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
`else
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;
`endif

    state_t state_q, state_d;

    logic [DATA_BITS-1:0] tx_mem_q [DEPTH];
    logic [DATA_BITS-1:0] tx_mem_d [DEPTH];
    logic [DATA_BITS-1:0] rx_mem_q [DEPTH];
    logic [DATA_BITS-1:0] rx_mem_d [DEPTH];
    logic [PW-1:0]        tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [PW-1:0]        rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 m_done_q, m_done_d;

    logic tx_full, tx_empty, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic launch_ok, done_rise;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal low
    // bits with differing wrap bits mean full.
    assign tx_full   = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
    assign tx_empty  = (tx_wr_q == tx_rd_q);
    assign rx_empty  = (rx_wr_q == rx_rd_q);
    assign tx_level  = tx_wr_q - tx_rd_q;
    assign rx_level  = rx_wr_q - rx_rd_q;

    assign tx_ready  = !tx_full;
    assign tx_push   = tx_valid && tx_ready;
    assign rx_valid  = !rx_empty;
    assign rx_pop    = rx_valid && rx_ready;
    assign rx_data   = rx_mem_q[rx_rd_q[AW-1:0]];
    assign m_data_out = hold_q;

    // A transfer only starts when its RX slot is already free, so the single
    // RX writer (this FSM) can never overflow the RX FIFO.
    assign launch_ok = !tx_empty && (rx_level < PW'(DEPTH));
    // Only the rising edge counts, so a level-held m_done stores one word.
    assign done_rise = m_done && !m_done_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
`ifdef SPI_XQ_GAP_EN
            gap_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
`ifdef SPI_XQ_GAP_EN
            gap_cnt_q <= gap_cnt_d;
`endif
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
`ifdef SPI_XQ_GAP_EN
        gap_cnt_d = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (launch_ok) state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                if (m_busy) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (done_rise) begin
`ifdef SPI_XQ_GAP_EN
                    state_d = ST_GAP;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef SPI_XQ_GAP_EN
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + GW'(1);
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        m_start = (state_q == ST_LAUNCH);
        active  = (state_q != ST_IDLE);
        tx_pop  = (state_q == ST_IDLE) && launch_ok;
        rx_push = (state_q == ST_WAIT_DONE) && done_rise;
    end

    // ---------------- FIFO and hold datapath ----------------
    always_comb begin
        tx_mem_d = tx_mem_q;
        rx_mem_d = rx_mem_q;
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        hold_d   = hold_q;
        m_done_d = m_done;
        if (tx_push) begin
            tx_mem_d[tx_wr_q[AW-1:0]] = tx_data;
            tx_wr_d = tx_wr_q + PW'(1);
        end
        if (tx_pop) begin
            hold_d  = tx_mem_q[tx_rd_q[AW-1:0]];
            tx_rd_d = tx_rd_q + PW'(1);
        end
        if (rx_push) begin
            rx_mem_d[rx_wr_q[AW-1:0]] = m_data_in;
            rx_wr_d = rx_wr_q + PW'(1);
        end
        if (rx_pop) begin
            rx_rd_d = rx_rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_mem_q <= '{default: '0};
            rx_mem_q <= '{default: '0};
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            hold_q   <= '0;
            m_done_q <= 1'b0;
        end else begin
            tx_mem_q <= tx_mem_d;
            rx_mem_q <= rx_mem_d;
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            hold_q   <= hold_d;
            m_done_q <= m_done_d;
        end
    end

endmodule

// File: tb/tb_spi_xfer_queue.sv
// -----------------------------------------------------------------------------
// Testbench for spi_xfer_queue. A queue-based reference model tracks the TX
// and RX contents and the transfer phase; a compare process checks every DUT
// output against it each cycle. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_spi_xfer_queue;

    localparam int W          = 8;
    localparam int DEPTH      = 4;
    localparam int GAP_CYCLES = 4;
    localparam int LW         = $clog2(DEPTH) + 1;
`ifdef SPI_XQ_GAP_EN
    localparam int GAP_LEN = GAP_CYCLES;
`else
    localparam int GAP_LEN = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [W-1:0]  tx_data = '0;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic [W-1:0]  rx_data;
    logic [LW-1:0] tx_level;
    logic [LW-1:0] rx_level;
    logic          active;
    logic          m_start;
    logic [W-1:0]  m_data_out;
    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    logic [W-1:0]  m_data_in = '0;

    spi_xfer_queue #(
        .DATA_BITS  (W),
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .tx_level   (tx_level),
        .rx_level   (rx_level),
        .active     (active),
        .m_start    (m_start),
        .m_data_out (m_data_out),
        .m_busy     (m_busy),
        .m_done     (m_done),
        .m_data_in  (m_data_in)
    );

    // ---------------- check bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] tx_model_q[$];
    logic [W-1:0] exp_q[$];        // expected RX words, head first
    bit           mdl_xfer;        // a word has been taken and its transfer is open
    bit           mdl_wait;        // master has reported busy, waiting for done
    int           mdl_gap;         // gap clocks still to elapse
    logic [W-1:0] mdl_hold;
    bit           mdl_done_prev;
    bit           do_push, do_pop, do_launch, do_busy, do_store;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_model_q.delete();
            exp_q.delete();
            mdl_xfer      = 1'b0;
            mdl_wait      = 1'b0;
            mdl_gap       = 0;
            mdl_hold      = '0;
            mdl_done_prev = 1'b0;
        end else begin
            do_push   = tx_valid && (tx_model_q.size() < DEPTH);
            do_pop    = rx_ready && (exp_q.size() > 0);
            do_launch = !mdl_xfer && (mdl_gap == 0) && (tx_model_q.size() > 0) && (exp_q.size() < DEPTH);
            do_busy   = mdl_xfer && !mdl_wait && m_busy;
            do_store  = mdl_xfer && mdl_wait && m_done && !mdl_done_prev;
            if (do_pop)    void'(exp_q.pop_front());
            if (do_store)  exp_q.push_back(m_data_in);
            if (do_launch) mdl_hold = tx_model_q.pop_front();
            if (do_push)   tx_model_q.push_back(tx_data);
            if (do_launch) begin
                mdl_xfer = 1'b1;
                mdl_wait = 1'b0;
            end else if (do_busy) begin
                mdl_wait = 1'b1;
            end else if (do_store) begin
                mdl_xfer = 1'b0;
                mdl_wait = 1'b0;
                mdl_gap  = GAP_LEN;
            end else if (mdl_gap > 0) begin
                mdl_gap--;
            end
            mdl_done_prev = m_done;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!reset) begin
            chk("cyc_tx_level", 32'(tx_level), 32'(tx_model_q.size()));
            chk("cyc_rx_level", 32'(rx_level), 32'(exp_q.size()));
            chk("cyc_tx_ready", 32'(tx_ready), 32'(tx_model_q.size() < DEPTH));
            chk("cyc_rx_valid", 32'(rx_valid), 32'(exp_q.size() > 0));
            chk("cyc_active", 32'(active), 32'(mdl_xfer || (mdl_gap > 0)));
            chk("cyc_m_start", 32'(m_start), 32'(mdl_xfer && !mdl_wait));
            chk("cyc_m_data_out", 32'(m_data_out), 32'(mdl_hold));
            if (exp_q.size() > 0) chk("cyc_rx_data", 32'(rx_data), 32'(exp_q[0]));
        end
    end

    // ---------------- automatic master responder ----------------
    bit manual = 1'b1;     // main thread drives m_busy/m_done itself
    bit stall  = 1'b0;     // master ignores m_start
    int done_hold_cfg = 0; // 0 = random m_done high time
    int mst_phase = 0;
    int mst_cnt   = 0;
    int mst_hold  = 0;
    int store_cyc = 0;
    bit store_seen = 1'b0;

    always @(negedge clk) begin
        if (!manual) begin
            if (reset) begin
                mst_phase = 0;
                m_busy    = 1'b0;
                m_done    = 1'b0;
            end else begin
                case (mst_phase)
                    0: begin
                        m_data_in = W'($urandom);
                        if (m_start && !stall) begin
                            m_busy    = 1'b1;
                            mst_cnt   = $urandom_range(0, 3);
                            mst_phase = 1;
                        end
                    end
                    1: begin
                        if (mst_cnt == 0) begin
                            m_busy     = 1'b0;
                            m_done     = 1'b1;
                            m_data_in  = W'($urandom);
                            mst_hold   = (done_hold_cfg > 0) ? done_hold_cfg : $urandom_range(1, 3);
                            mst_phase  = 2;
                            store_cyc  = cyc + 1;
                            store_seen = 1'b1;
                        end else begin
                            mst_cnt--;
                        end
                    end
                    default: begin
                        m_data_in = W'($urandom);
                        mst_hold--;
                        if (mst_hold == 0) begin
                            m_done    = 1'b0;
                            mst_phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- store-to-next-start monitor ----------------
    bit meas_arm  = 1'b0;
    int gap_meas  = -1;
    bit start_prev = 1'b0;

    always @(negedge clk) begin
        if (m_start && !start_prev && meas_arm && store_seen) begin
            gap_meas = cyc - store_cyc;
            meas_arm = 1'b0;
        end
        start_prev = m_start;
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after the accepting edge
    // with tx_valid still high so pushes can be chained back to back.
    task automatic push_word(input logic [W-1:0] d, input int budget);
        bit   ok;
        logic rdy;
        ok = 1'b0;
        tx_valid = 1'b1;
        tx_data  = d;
        for (int i = 0; i < budget && !ok; i++) begin
            rdy = tx_ready;
            @(negedge clk);
            if (rdy) ok = 1'b1;
        end
        if (!ok) tx_valid = 1'b0;
        chk("push_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_drain(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (tx_level == 0 && rx_level == 0 && !active && !m_busy && !m_done && mst_phase == 0)
                ok = 1'b1;
        end
        chk("drain", 32'(ok), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        int prev_rx;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_tx_level", 32'(tx_level), 32'd0);
        chk("rst_rx_level", 32'(rx_level), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_m_start", 32'(m_start), 32'd0);
        chk("rst_m_data_out", 32'(m_data_out), 32'd0);
        reset = 1'b0;

        // Single transfer with a hand-driven master
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("a5_start_not_yet", 32'(m_start), 32'd0);
        chk("a5_tx_level_1", 32'(tx_level), 32'd1);
        @(negedge clk);
        chk("a5_start", 32'(m_start), 32'd1);
        chk("a5_data_out", 32'(m_data_out), 32'hA5);
        chk("a5_tx_level_0", 32'(tx_level), 32'd0);
        chk("a5_active", 32'(active), 32'd1);
        m_busy = 1'b1;
        @(negedge clk);
        chk("a5_start_drop", 32'(m_start), 32'd0);
        chk("a5_data_hold", 32'(m_data_out), 32'hA5);
        m_busy    = 1'b0;
        m_done    = 1'b1;
        m_data_in = 8'h3C;
        @(negedge clk);
        m_done    = 1'b0;
        m_data_in = 8'h00;
        chk("a5_rx_valid", 32'(rx_valid), 32'd1);
        chk("a5_rx_data", 32'(rx_data), 32'h3C);
        chk("a5_rx_level", 32'(rx_level), 32'd1);
        chk("a5_data_hold2", 32'(m_data_out), 32'hA5);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("a5_rx_popped", 32'(rx_level), 32'd0);
        wait_drain(50);

        // Stalled master: TX fills up behind the held word
        manual = 1'b0;
        stall  = 1'b1;
        push_word(8'h01, 4);
        push_word(8'h02, 4);
        push_word(8'h03, 4);
        push_word(8'h04, 4);
        push_word(8'h05, 4);
        tx_data = 8'h06;
        chk("full_tx_ready", 32'(tx_ready), 32'd0);
        chk("full_tx_level", 32'(tx_level), 32'd4);
        chk("full_hold", 32'(m_data_out), 32'h01);
        chk("full_m_start", 32'(m_start), 32'd1);
        repeat (3) @(negedge clk);
        chk("full_still_4", 32'(tx_level), 32'd4);
        rx_ready = 1'b1;
        stall    = 1'b0;
        push_word(8'h06, 30);
        tx_valid = 1'b0;
        wait_drain(300);

        // RX full blocks launches until one word is consumed
        rx_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) push_word(W'($urandom), 40);
        tx_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (rx_level == LW'(DEPTH)) ok = 1'b1;
            else @(negedge clk);
        end
        chk("rxfull_reached", 32'(ok), 32'd1);
        repeat (20) @(negedge clk);
        chk("rxfull_rx_level", 32'(rx_level), 32'd4);
        chk("rxfull_tx_level", 32'(tx_level), 32'd1);
        chk("rxfull_m_start", 32'(m_start), 32'd0);
        chk("rxfull_active", 32'(active), 32'd0);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("rxpop_no_start_yet", 32'(m_start), 32'd0);
        chk("rxpop_level_3", 32'(rx_level), 32'd3);
        @(negedge clk);
        chk("rxpop_start", 32'(m_start), 32'd1);
        rx_ready = 1'b1;
        wait_drain(300);

        // m_done held high for three cycles stores one word
        rx_ready      = 1'b0;
        done_hold_cfg = 3;
        push_word(8'h5A, 4);
        tx_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (rx_level != 0) ok = 1'b1;
            else @(negedge clk);
        end
        chk("hold_store_seen", 32'(ok), 32'd1);
        repeat (6) @(negedge clk);
        chk("hold_one_write", 32'(rx_level), 32'd1);
        done_hold_cfg = 0;
        rx_ready = 1'b1;
        wait_drain(100);

        // Reset during WAIT_DONE, then a stale done pulse
        manual   = 1'b1;
        rx_ready = 1'b0;
        push_word(8'h11, 10);
        push_word(8'h22, 10);
        push_word(8'h33, 10);
        tx_valid = 1'b0;
        chk("rstmid_launch", 32'(m_start), 32'd1);
        m_busy = 1'b1;
        @(negedge clk);
        chk("rstmid_tx_level", 32'(tx_level), 32'd2);
        chk("rstmid_wait", 32'(m_start), 32'd0);
        chk("rstmid_active", 32'(active), 32'd1);
        chk("rstmid_hold", 32'(m_data_out), 32'h11);
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid_tx_clr", 32'(tx_level), 32'd0);
        chk("rstmid_rx_clr", 32'(rx_level), 32'd0);
        chk("rstmid_m_start", 32'(m_start), 32'd0);
        chk("rstmid_active_clr", 32'(active), 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        m_busy = 1'b0;
        @(negedge clk);
        m_done    = 1'b1;
        m_data_in = 8'h77;
        repeat (2) @(negedge clk);
        m_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("stale_done_rx_level", 32'(rx_level), 32'd0);
        chk("stale_done_rx_valid", 32'(rx_valid), 32'd0);
        chk("stale_done_active", 32'(active), 32'd0);
        manual = 1'b0;

        // Store-to-next-start spacing for back-to-back words
        rx_ready      = 1'b1;
        done_hold_cfg = 1;
        store_seen    = 1'b0;
        gap_meas      = -1;
        meas_arm      = 1'b1;
        push_word(8'hC1, 10);
        push_word(8'hC2, 10);
        tx_valid = 1'b0;
        for (int i = 0; i < 200 && meas_arm; i++) @(negedge clk);
        chk("b2b_start_spacing", 32'(gap_meas), 32'(GAP_LEN + 1));
        meas_arm      = 1'b0;
        done_hold_cfg = 0;
        wait_drain(100);

        // Randomized traffic against the model
        for (int seg = 0; seg < 2; seg++) begin
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                tx_valid = ($urandom_range(0, 99) < ((seg == 0) ? 30 : 70));
                tx_data  = W'($urandom);
                rx_ready = ($urandom_range(0, 99) < ((seg == 0) ? 60 : 20));
                stall    = ($urandom_range(0, 99) < 10);
            end
        end
        tx_valid = 1'b0;
        rx_ready = 1'b1;
        stall    = 1'b0;
        wait_drain(500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
